// File: rtl/nor3_bist_pkg.sv
// nor3_bist_pkg: state encoding, last vector index and NOR reference value for the NOR3 BIST sequencer.
package nor3_bist_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam logic [2:0] VEC_LAST = 3'd7;
    function automatic logic nor3_expected(input logic [2:0] vec);
        return ~|vec;
    endfunction
endpackage

// File: rtl/nor3_settle_timer.sv
// nor3_settle_timer: down-counter that sets expired once load_val cycles have passed since load.
module nor3_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expired
);
    logic [3:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
    assign expired = cnt == 4'd0;
endmodule

// File: rtl/nor3_bist_ctrl.sv
// nor3_bist_ctrl: sweeps {A,B,C} through all 8 vectors, checks F against NOR and reports pass/fail.
// Optional first-failure capture on fail_vec when NOR3_BIST_FAIL_CAPTURE_EN is defined.
module nor3_bist_ctrl
    import nor3_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_SWEEPS    = 1,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             F,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef NOR3_BIST_FAIL_CAPTURE_EN
    output logic [2:0]       fail_vec,
`endif
    output logic [ERR_W-1:0] err_count
);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] SWEEP_LAST  = 4'(NUM_SWEEPS - 1);
    state_t            state;
    logic [2:0]        vec;
    logic [3:0]        sweep;
    logic [ERR_W-1:0]  err_nxt;
    logic              active, expired, mismatch, run_end, load;
    assign active    = state == DRIVE || state == SAMPLE;
    assign {A, B, C} = active ? vec : 3'b000;
    assign busy      = active;
    assign done      = state == DONE;
    assign mismatch  = state == SAMPLE && F != nor3_expected(vec);
    assign err_nxt   = (mismatch && err_count != '1) ? err_count + 1'b1 : err_count;
    assign run_end   = vec == VEC_LAST && sweep == SWEEP_LAST;
    // Reload the settle timer on every entry into DRIVE.
    assign load      = (state == IDLE && start) || (state == SAMPLE && !run_end);
    nor3_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (SETTLE_LOAD),
        .expired  (expired)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            sweep     <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= DRIVE;
                    vec       <= '0;
                    sweep     <= '0;
                    err_count <= '0;
                    pass      <= 1'b0;
                end
                DRIVE: if (expired) state <= SAMPLE;
                SAMPLE: begin
                    err_count <= err_nxt;
                    if (run_end) begin
                        state <= DONE;
                        pass  <= err_nxt == '0;
                    end else begin
                        state <= DRIVE;
                        vec   <= vec + 3'd1;
                        if (vec == VEC_LAST) sweep <= sweep + 4'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef NOR3_BIST_FAIL_CAPTURE_EN
    // err_count only grows within a run, so zero marks the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fail_vec <= '0;
        else if (state == IDLE && start) fail_vec <= '0;
        else if (mismatch && err_count == '0) fail_vec <= vec;
    end
`endif
endmodule

// File: tb/tb_nor3_bist_ctrl.sv
// tb_nor3_bist_ctrl: directed + random runs on two configurations, checked cycle by cycle against a sweep model.
module tb_nor3_bist_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [2];
    logic       f [2];
    logic       a [2], b [2], c [2], busy [2], done [2], pass [2];
    logic [4:0] err0;
    logic [3:0] err1;
`ifdef NOR3_BIST_FAIL_CAPTURE_EN
    logic [2:0] fv [2];
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nor3_bist_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .F(f[0]),
        .A(a[0]), .B(b[0]), .C(c[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
`ifdef NOR3_BIST_FAIL_CAPTURE_EN
        .fail_vec(fv[0]),
`endif
        .err_count(err0)
    );

    nor3_bist_ctrl #(.SETTLE_CYCLES(1), .NUM_SWEEPS(3), .ERR_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .F(f[1]),
        .A(a[1]), .B(b[1]), .C(c[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
`ifdef NOR3_BIST_FAIL_CAPTURE_EN
        .fail_vec(fv[1]),
`endif
        .err_count(err1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int errc(input int d);
        return d != 0 ? int'(err1) : int'(err0);
    endfunction

    function automatic int abc(input int d);
        return int'({a[d], b[d], c[d]});
    endfunction

    // mode: 0 good NOR, 1 F stuck 0, 2 F stuck 1, 3 random F
    task automatic run(input int d, input int mode, input int restart_cyc, input int abort_cyc);
        int s    = d != 0 ? 1 : 2;
        int n    = d != 0 ? 3 : 1;
        int emax = d != 0 ? 15 : 31;
        int len  = 8 * n * (s + 1);
        int err  = 0;
        int first = -1;
        int v;
        bit act, smp, good;
        @(negedge clk);
        start[d] = 1'b1;
        for (int cyc = 1; cyc <= len + 1; cyc++) begin
            @(negedge clk);
            start[d] = cyc == restart_cyc;
            if (cyc == abort_cyc) begin
                #1 rst_n = 1'b0;
                #1;
                chk("abort_abc", abc(d), 0);
                chk("abort_busy", int'(busy[d]), 0);
                chk("abort_done", int'(done[d]), 0);
                chk("abort_pass", int'(pass[d]), 0);
                chk("abort_err", errc(d), 0);
                @(negedge clk);
                rst_n = 1'b1;
                start[d] = 1'b0;
                return;
            end
            act  = cyc <= len;
            v    = ((cyc - 1) / (s + 1)) % 8;
            smp  = act && ((cyc - 1) % (s + 1)) == s;
            good = v == 0;
            chk("abc", abc(d), act ? v : 0);
            chk("busy", int'(busy[d]), int'(act));
            chk("done", int'(done[d]), int'(!act));
            chk("err_count", errc(d), err);
            chk("pass", int'(pass[d]), int'(!act && err == 0));
`ifdef NOR3_BIST_FAIL_CAPTURE_EN
            if (!act) chk("fail_vec", int'(fv[d]), first < 0 ? 0 : first);
`endif
            f[d] = mode == 0 ? good : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : 1'($urandom);
            if (smp && f[d] != good) begin
                if (first < 0) first = v;
                if (err < emax) err++;
            end
        end
        @(negedge clk);
        chk("idle_done", int'(done[d]), 0);
        chk("idle_busy", int'(busy[d]), 0);
        chk("idle_pass", int'(pass[d]), int'(err == 0));
        chk("idle_err", errc(d), err);
    endtask

    initial begin
        start[0] = 1'b0; start[1] = 1'b0;
        f[0] = 1'b0; f[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_abc", abc(d), 0);
            chk("rst_busy", int'(busy[d]), 0);
            chk("rst_done", int'(done[d]), 0);
            chk("rst_pass", int'(pass[d]), 0);
            chk("rst_err", errc(d), 0);
        end
        rst_n = 1'b1;
        run(0, 0, 0, 0);
        run(0, 1, 0, 0);
        run(1, 2, 0, 0);
        run(0, 2, 0, 0);
        run(0, 0, 10, 0);
        run(0, 1, 0, 12);
        run(0, 0, 0, 0);
        run(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) run(i % 2, 3, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
